// File: rtl/forwarding_ctrl.sv
// Operand-bypass control: tracks destinations of in-flight instructions (EX, MEM, WB),
// drives the ALU operand mux selectors and raises a load-use stall.
module forwarding_ctrl #(
  parameter  int REG_ADDR_SIZE = 5,
  parameter  int DEPTH         = 3,
  parameter  int CNT_SIZE      = 16,
  localparam int SEL_SIZE      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic                     issue_wr_en,
  input  logic [REG_ADDR_SIZE-1:0] issue_wr_addr,
  input  logic                     issue_is_load,
  input  logic [REG_ADDR_SIZE-1:0] rs_addr,
  input  logic [REG_ADDR_SIZE-1:0] rt_addr,
  input  logic                     rs_used,
  input  logic                     rt_used,
  output logic [SEL_SIZE-1:0]      sel_rs,
  output logic [SEL_SIZE-1:0]      sel_rt,
  output logic                     load_use_stall,
  output logic [CNT_SIZE-1:0]      stall_count
);

  typedef struct packed {
    logic                     valid;
    logic                     wr_en;
    logic [REG_ADDR_SIZE-1:0] wr_addr;
    logic                     is_load;
  } slot_t;

  slot_t               slot_q [DEPTH];
  slot_t               slot0_d;
  logic [CNT_SIZE-1:0] stall_cnt_q;
  logic [CNT_SIZE-1:0] stall_cnt_d;
  logic [DEPTH-1:0]    rs_match;
  logic [DEPTH-1:0]    rt_match;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rs_match[k] = rs_used && slot_q[k].valid && slot_q[k].wr_en &&
                    (slot_q[k].wr_addr == rs_addr) && (rs_addr != '0);
      rt_match[k] = rt_used && slot_q[k].valid && slot_q[k].wr_en &&
                    (slot_q[k].wr_addr == rt_addr) && (rt_addr != '0);
    end
  end

  assign load_use_stall = (rs_match[0] || rt_match[0]) && slot_q[0].is_load;

  // Scan oldest to youngest so the youngest producer overwrites the selection.
  always_comb begin
    sel_rs = '0;
    sel_rt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs_match[k]) sel_rs = SEL_SIZE'(k + 1);
      if (rt_match[k]) sel_rt = SEL_SIZE'(k + 1);
    end
    if (load_use_stall) begin
      sel_rs = '0;
      sel_rt = '0;
    end
  end

  always_comb begin
    slot0_d = '0;
    if (issue_valid && !flush && !load_use_stall) begin
      slot0_d.valid   = 1'b1;
      slot0_d.wr_en   = issue_wr_en;
      slot0_d.wr_addr = issue_wr_addr;
      slot0_d.is_load = issue_is_load;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_SIZE'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every slot shifts from the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the slot array is a handful of flops, not RAM, so it is reset to clear stale valid bits.
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      stall_cnt_q <= '0;
    end else if (enable) begin
      slot_q[0] <= slot0_d;
      for (int k = 1; k < DEPTH; k++) slot_q[k] <= slot_q[k-1];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Directed bench for forwarding_ctrl: expectations are queued as stimulus is applied
// and drained against the DUT outputs at each sample point.
module tb_forwarding_ctrl;

  localparam int RW  = 5;
  localparam int DP  = 3;
  localparam int CW  = 4;
  localparam int SW  = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          flush;
  logic          issue_valid;
  logic          issue_wr_en;
  logic [RW-1:0] issue_wr_addr;
  logic          issue_is_load;
  logic [RW-1:0] rs_addr;
  logic [RW-1:0] rt_addr;
  logic          rs_used;
  logic          rt_used;
  logic [SW-1:0] sel_rs;
  logic [SW-1:0] sel_rt;
  logic          load_use_stall;
  logic [CW-1:0] stall_count;

  forwarding_ctrl #(.REG_ADDR_SIZE(RW), .DEPTH(DP), .CNT_SIZE(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_wr_addr(issue_wr_addr), .issue_is_load(issue_is_load),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .sel_rs(sel_rs), .sel_rt(sel_rt), .load_use_stall(load_use_stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef enum {O_RS, O_RT, O_STALL, O_CNT} out_e;
  typedef struct {
    out_e        o;
    logic [31:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_o(input out_e o, input logic [31:0] v, input string tag);
    exp_t e;
    e.o = o; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.o)
        O_RS:    obs = 32'(sel_rs);
        O_RT:    obs = 32'(sel_rt);
        O_STALL: obs = 32'(load_use_stall);
        default: obs = 32'(stall_count);
      endcase
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] a, input logic ld);
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_addr = a; issue_is_load = ld;
    tick();
    issue_valid = 1'b0; issue_wr_en = 1'b0; issue_is_load = 1'b0;
  endtask

  task automatic drain();
    rs_used = 1'b0; rt_used = 1'b0; issue_valid = 1'b0;
    repeat (DP) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_wr_en = 1'b0; issue_wr_addr = '0; issue_is_load = 1'b0;
    rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
    #1;
    expect_o(O_RS, 0, "reset_sel_rs"); expect_o(O_RT, 0, "reset_sel_rt");
    expect_o(O_STALL, 0, "reset_stall"); expect_o(O_CNT, 0, "reset_cnt");
    sample();
    #10 reset_n = 1'b1;
    tick();

    // Single producer walks through EX, MEM, WB and leaves.
    issue(5'd3, 1'b0);
    rs_addr = 5'd3; rs_used = 1'b1;
    expect_o(O_RS, 1, "walk_ex");  sample(); tick();
    expect_o(O_RS, 2, "walk_mem"); sample(); tick();
    expect_o(O_RS, 3, "walk_wb");  sample(); tick();
    expect_o(O_RS, 0, "walk_gone"); sample();
    drain();

    // Two producers of r5: youngest wins.
    issue(5'd5, 1'b0);
    issue(5'd5, 1'b0);
    rs_addr = 5'd5; rs_used = 1'b1; rt_addr = 5'd5; rt_used = 1'b1;
    expect_o(O_RS, 1, "youngest_rs"); expect_o(O_RT, 1, "youngest_rt"); sample();
    tick();
    expect_o(O_RS, 2, "youngest_after_bubble"); sample();
    drain();

    // Load-use: stall while load is in EX; the held instruction must not enter slot 0.
    issue(5'd7, 1'b1);
    rt_addr = 5'd7; rt_used = 1'b1;
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_addr = 5'd7; issue_is_load = 1'b0;
    expect_o(O_STALL, 1, "lu_stall"); expect_o(O_RT, 0, "lu_sel_forced");
    expect_o(O_CNT, 0, "lu_cnt_before"); sample();
    tick();
    issue_valid = 1'b0; issue_wr_en = 1'b0;
    expect_o(O_STALL, 0, "lu_released"); expect_o(O_RT, 2, "lu_fwd_mem");
    expect_o(O_CNT, 1, "lu_cnt_after"); sample();
    drain();

    // Register 0 is never forwarded; unused operands select the register file.
    issue(5'd0, 1'b0);
    rs_addr = 5'd0; rs_used = 1'b1; rt_addr = 5'd0; rt_used = 1'b1;
    expect_o(O_RS, 0, "r0_rs"); expect_o(O_RT, 0, "r0_rt"); sample();
    rs_used = 1'b0; rt_used = 1'b0;
    issue(5'd9, 1'b0);
    rs_addr = 5'd9; rs_used = 1'b0; rt_addr = 5'd9; rt_used = 1'b1;
    expect_o(O_RS, 0, "unused_rs"); expect_o(O_RT, 1, "used_rt"); sample();
    drain();

    // enable=0 freezes slots; flush turns the issuing instruction into a bubble.
    issue(5'd4, 1'b0);
    rs_addr = 5'd4; rs_used = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_o(O_RS, 1, "hold_rs"); sample();
    end
    enable = 1'b1;
    flush = 1'b1;
    issue(5'd11, 1'b0);
    flush = 1'b0;
    expect_o(O_RS, 2, "flush_older_moves"); sample();
    rs_addr = 5'd11;
    expect_o(O_RS, 0, "flush_bubble"); sample();
    rs_used = 1'b0;

    // Stall under enable=0 holds the counter; flush plus stall yields one bubble.
    issue(5'd8, 1'b1);
    rs_addr = 5'd8; rs_used = 1'b1;
    expect_o(O_STALL, 1, "ld8_stall"); expect_o(O_RS, 0, "ld8_sel_forced"); sample();
    enable = 1'b0;
    tick();
    expect_o(O_STALL, 1, "ld8_hold_stall"); expect_o(O_CNT, 1, "ld8_hold_cnt"); sample();
    enable = 1'b1; flush = 1'b1;
    issue(5'd8, 1'b1);
    flush = 1'b0;
    expect_o(O_STALL, 0, "ld8_released"); expect_o(O_RS, 2, "ld8_fwd_mem");
    expect_o(O_CNT, 2, "ld8_cnt"); sample();
    rs_used = 1'b0;

    // Counter saturates at all-ones (CW=4 -> 15).
    for (int i = 0; i < 13; i++) begin
      issue(5'd8, 1'b1);
      rs_used = 1'b1;
      tick();
      rs_used = 1'b0;
    end
    expect_o(O_CNT, 15, "cnt_reach_max"); sample();
    for (int i = 0; i < 2; i++) begin
      issue(5'd8, 1'b1);
      rs_used = 1'b1;
      tick();
      rs_used = 1'b0;
    end
    expect_o(O_CNT, 15, "cnt_saturated"); sample();
    drain();

    // Asynchronous reset mid-run with three valid slots.
    issue(5'd1, 1'b0);
    issue(5'd6, 1'b0);
    issue(5'd2, 1'b1);
    rs_addr = 5'd6; rs_used = 1'b1;
    expect_o(O_RS, 2, "pre_reset_rs"); expect_o(O_STALL, 0, "pre_reset_nostall"); sample();
    rt_addr = 5'd2; rt_used = 1'b1;
    expect_o(O_STALL, 1, "pre_reset_stall"); expect_o(O_RS, 0, "pre_reset_forced"); sample();
    reset_n = 1'b0;
    expect_o(O_STALL, 0, "async_rst_stall"); expect_o(O_RS, 0, "async_rst_rs");
    expect_o(O_RT, 0, "async_rst_rt"); expect_o(O_CNT, 0, "async_rst_cnt"); sample();
    rt_used = 1'b0;
    expect_o(O_RS, 0, "async_rst_rs_nostall"); sample();
    reset_n = 1'b1;
    tick();
    expect_o(O_RS, 0, "post_rst_rs"); expect_o(O_CNT, 0, "post_rst_cnt"); sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
